// File: rtl/vector_op_pkg.sv
// Shared vector-instruction types plus the VGPR operand-use helpers that the
// issue controller needs for hazard checks.
package vector_op_pkg;

  localparam int VGPR_IDX_W   = 8;
  localparam int VGPR_SRC_BIT = 8;

  typedef enum logic [2:0] {
    FMT_VOP1   = 3'd0,
    FMT_VOP2   = 3'd1,
    FMT_VOPC   = 3'd2,
    FMT_VOP3   = 3'd3,
    FMT_VOP3P  = 3'd4,
    FMT_VINTRP = 3'd5
  } vinst_fmt_e;

  typedef struct packed {
    vinst_fmt_e            fmt;
    logic [7:0]            opcode;
    logic [VGPR_IDX_W-1:0] vdst;
    logic [8:0]            src0;
    logic [8:0]            src1;
    logic [8:0]            src2;
  } vector_inst_t;

  // Bit n set means srcN names a VGPR (index in srcN[7:0]).
  function automatic logic [2:0] vinst_src_vgpr_mask(input vector_inst_t inst);
    logic [2:0] mask;
    mask = '0;
    case (inst.fmt)
      FMT_VOP1:            mask[0] = inst.src0[VGPR_SRC_BIT];
      FMT_VOP2, FMT_VOPC:  mask    = {1'b0, 1'b1, inst.src0[VGPR_SRC_BIT]};
      FMT_VOP3, FMT_VOP3P: mask    = {inst.src2[VGPR_SRC_BIT], inst.src1[VGPR_SRC_BIT],
                                      inst.src0[VGPR_SRC_BIT]};
      FMT_VINTRP:          mask[0] = 1'b1;
      default:             mask    = '0;
    endcase
    return mask;
  endfunction

  // VOPC results land in VCC, never in a VGPR.
  function automatic logic vinst_writes_vgpr(input vector_inst_t inst);
    return inst.fmt != FMT_VOPC;
  endfunction

endpackage

// File: rtl/vector_scoreboard.sv
// Per-VGPR busy bits: one set port (issue), one clear port (writeback),
// three source lookups and one destination lookup.
module vector_scoreboard
  import vector_op_pkg::*;
#(
  parameter int NUM_VGPR = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [VGPR_IDX_W-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [VGPR_IDX_W-1:0] clr_idx,
  input  logic [VGPR_IDX_W-1:0] src0_idx,
  input  logic [VGPR_IDX_W-1:0] src1_idx,
  input  logic [VGPR_IDX_W-1:0] src2_idx,
  input  logic [VGPR_IDX_W-1:0] dst_idx,
  output logic                  src0_busy,
  output logic                  src1_busy,
  output logic                  src2_busy,
  output logic                  dst_busy
);

  logic [NUM_VGPR-1:0] busy;

  // NOTE: non-blocking assignments; the later set overrides an earlier clear of
  // the same bit within this block, which gives "set wins" on a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_idx] <= 1'b0;
      if (set_en) busy[set_idx] <= 1'b1;
    end
  end

  assign src0_busy = busy[src0_idx];
  assign src1_busy = busy[src1_idx];
  assign src2_busy = busy[src2_idx];
  assign dst_busy  = busy[dst_idx];

endmodule

// File: rtl/vector_issue_ctrl.sv
// In-order issue queue between the vector decoder and the VALU, holding the
// head instruction back while any VGPR it reads or writes is still in flight.
module vector_issue_ctrl
  import vector_op_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int NUM_VGPR = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  vector_inst_t            in_inst,
  output logic                    dec_stall,
  output logic                    issue_valid,
  input  logic                    issue_ready,
  output vector_inst_t            issue_inst,
  input  logic                    wb_valid,
  input  logic [VGPR_IDX_W-1:0]   wb_vdst,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  vector_inst_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  vector_inst_t     head;
  logic             full, empty, fire, push, hazard;
  logic [2:0]       src_mask;
  logic             src0_busy, src1_busy, src2_busy, dst_busy;

  assign full  = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  assign head  = mem[rd_ptr];

  assign src_mask = vinst_src_vgpr_mask(head);
  assign hazard   = |(src_mask & {src2_busy, src1_busy, src0_busy})
                  | (vinst_writes_vgpr(head) & dst_busy);

  // Hazard inputs are all registered, so issue_valid holds until accepted.
  assign issue_valid = !empty && !hazard && !flush;
  assign issue_inst  = head;
  assign fire        = issue_valid && issue_ready;
  // A full queue still accepts when the head pops in the same cycle.
  assign push        = in_valid && !flush && (!full || fire);
  // The last slot is kept for a decode result already on its way.
  assign dec_stall   = count >= CNT_W'(DEPTH - 1);

  vector_scoreboard #(.NUM_VGPR(NUM_VGPR)) u_sb (
    .clk       (clk),
    .reset     (reset),
    .set_en    (fire && vinst_writes_vgpr(head)),
    .set_idx   (head.vdst),
    .clr_en    (wb_valid),
    .clr_idx   (wb_vdst),
    .src0_idx  (head.src0[VGPR_IDX_W-1:0]),
    .src1_idx  (head.src1[VGPR_IDX_W-1:0]),
    .src2_idx  (head.src2[VGPR_IDX_W-1:0]),
    .dst_idx   (head.vdst),
    .src0_busy (src0_busy),
    .src1_busy (src1_busy),
    .src2_busy (src2_busy),
    .dst_busy  (dst_busy)
  );

  // NOTE: queue storage has no reset; count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_inst;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fire) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (in_valid && full && !fire) overflow <= 1'b1;
    end
  end

endmodule
